mmio_board_input_reader: RTL
============================

// Module: mmio_board_input_reader
// PURPOSE
//  CPU-facing reader for the board input pins: the input-side counterpart of the
//  display/LED output path. Synchronises and debounces key[4:0] and Switch[5:0],
//  latches key-press events and raises a level IRQ. The pipeline reads it through a
//  word-addressed MMIO slot with a 1-cycle registered read, like data memory.
// PARAMETERS
//  DEBOUNCE_CYCLES  20000  consecutive stable clocks before a debounced bit changes (>=2)
//  CNT_W            15     debounce counter width; must hold DEBOUNCE_CYCLES-1
//  NKEY             5      number of push keys
//  NSW              6      number of slide switches
// PORTS
//  clk        in   1      system clock, all state on posedge
//  rst        in   1      synchronous, active-high reset
//  key        in   NKEY   raw push keys, async, 1 = pressed
//  Switch     in   NSW    raw slide switches, async, 1 = on
//  cs         in   1      slot select from pipeline MEM stage
//  we         in   1      write strobe (qualified by cs)
//  addr       in   4      byte offset within slot; addr[1:0] ignored
//  wdata      in   32     write data
//  rdata      out  32     registered read data, valid the cycle after cs&!we
//  irq        out  1      |(key_event & irq_en), registered
// BEHAVIOUR
//  Reset: rdata=0, irq=0, sync flops=0, debounced states=0, counters=0, key_event=0, irq_en=0.
//  Sync: 2-flop synchroniser per input bit; no logic between the two flops.
//  Debounce per bit: if sync!=stable then cnt<=cnt+1, else cnt<=0;
//   when sync!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=sync, cnt<=0.
//   Pin edge -> stable change = DEBOUNCE_CYCLES+2 clocks; a glitch shorter than
//   DEBOUNCE_CYCLES synced clocks never changes stable; cnt never wraps.
//  Events: key_event[i] set on the same edge that key stable[i] goes 0->1;
//   release (1->0) sets nothing. Switches generate no events.
//  Register map (word offsets):
//   0x0 KEY_STATE  RO  {27'b0, key stable}
//   0x4 SW_STATE   RO  {26'b0, Switch stable}
//   0x8 KEY_EVENT  RW1C bits[NKEY-1:0]; write 1 clears, write 0 keeps
//   0xC IRQ_EN     RW  bits[NKEY-1:0]; upper bits read 0, writes ignored
//  Writes to RO offsets: ignored. Reads with cs=0: rdata holds last value.
//  Read: rdata <= mux(addr) on edge where cs&!we; value sampled pre-write
//   (a read never returns same-cycle write data; cs&we&read impossible by protocol).
//  Simultaneous set and W1C on same event bit in one cycle: set wins (bit stays 1).
//  irq: registered from next-state key_event & irq_en; drops 1 clock after clearing write.
//  Reset mid-debounce or with pending events: everything returns to reset values
//   next edge; a key held through reset re-reports press after DEBOUNCE_CYCLES+2 clocks.
// STRUCTURE
//  Shared header io_map.vh: slot base address, offsets KEY_STATE/SW_STATE/KEY_EVENT/
//   IRQ_EN, NKEY/NSW defaults; used also by the pipeline address decoder.
//  Sub-module debounce_bit (sync pair + counter + stable flop, param DEBOUNCE_CYCLES,
//   CNT_W, outputs stable and rise pulse), instantiated NKEY+NSW times via generate.
//  Top: register file, W1C logic, read mux, irq flop.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, CNT_W=3; clk period 20 ns, rst high 15 ns)
//  Reset: hold rst 2 clks with key=5'h1F -> rdata=0, irq=0; read 0x0 right after = 0.
//  Debounce: key[0] 0->1 held -> KEY_STATE reads 1 no earlier than 6 clks after edge,
//   KEY_EVENT=0x01; key[0] high for 3 clks then low -> KEY_STATE and KEY_EVENT stay 0.
//  Switch: Switch=6'h2A held 10 clks -> read 0x4 returns 0x0000002A, KEY_EVENT unchanged.
//  IRQ/W1C: IRQ_EN=0x1F, press key[3] -> irq=1; write 0x8 with 0x01 -> irq stays 1;
//   write 0x08 -> KEY_EVENT=0, irq=0 one clock later.
//  Collision: W1C key[2] on the same edge key[2] stable rises -> KEY_EVENT bit2 = 1.
//  Reset mid-op: assert rst while cnt of key[1] is 2 and KEY_EVENT=0x10 -> all 0 next
//   edge; key[1] still held -> event bit1 sets 6 clks after rst deasserts.

Source files
------------

// File: rtl/mmio_board_input_reader_pkg.sv
// Shared I/O map for the board input reader: slot base, register offsets and default widths.
// Also used by the pipeline address decoder to recognise the input slot.
package mmio_board_input_reader_pkg;

  localparam int unsigned NKEY_DEF = 5;
  localparam int unsigned NSW_DEF  = 6;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;

  localparam logic [DATA_W-1:0] IO_SLOT_BASE = 32'hFFFF_FC70;

  localparam logic [ADDR_W-1:0] OFF_KEY_STATE = 4'h0;
  localparam logic [ADDR_W-1:0] OFF_SW_STATE  = 4'h4;
  localparam logic [ADDR_W-1:0] OFF_KEY_EVENT = 4'h8;
  localparam logic [ADDR_W-1:0] OFF_IRQ_EN    = 4'hC;

  // Word select within the slot; byte lanes addr[1:0] are ignored.
  typedef enum logic [1:0] {
    REG_KEY_STATE = OFF_KEY_STATE[3:2],
    REG_SW_STATE  = OFF_SW_STATE[3:2],
    REG_KEY_EVENT = OFF_KEY_EVENT[3:2],
    REG_IRQ_EN    = OFF_IRQ_EN[3:2]
  } reg_sel_e;

  function automatic logic in_io_slot(input logic [DATA_W-1:0] byte_addr);
    return (byte_addr & ~32'h0000_000F) == IO_SLOT_BASE;
  endfunction

endpackage

// File: rtl/mmio_board_input_reader_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and debounced state.
// rise_c pulses combinationally on the edge where stable goes 0->1.
module mmio_board_input_reader_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic rise_c
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             differ_c;
  logic             done_c;

  assign differ_c = (s2 != stable);
  assign done_c   = differ_c && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise_c   = done_c && s2;

  // Counter only runs while the synced value disagrees, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (done_c) begin
        stable <= s2;
        cnt    <= '0;
      end else if (differ_c) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mmio_board_input_reader.sv
// CPU-facing reader for board keys and switches: debounced state, latched key-press
// events with write-1-to-clear, per-key IRQ enable and a 1-cycle registered MMIO read.
module mmio_board_input_reader
  import mmio_board_input_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 15,
  parameter int unsigned NKEY            = NKEY_DEF,
  parameter int unsigned NSW             = NSW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NKEY-1:0]   key,
  input  logic [NSW-1:0]    Switch,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  logic [NKEY-1:0]   key_stable;
  logic [NKEY-1:0]   key_rise_c;
  logic [NSW-1:0]    sw_stable;
  logic [NSW-1:0]    unused_sw_rise;
  logic              unused_bits;

  logic [NKEY-1:0]   key_event;
  logic [NKEY-1:0]   irq_en;
  logic [NKEY-1:0]   key_event_nx_c;
  logic [NKEY-1:0]   irq_en_nx_c;
  logic [NKEY-1:0]   w1c_c;
  logic [DATA_W-1:0] rdata_nx_c;
  reg_sel_e          sel_c;
  logic              wr_c;
  logic              rd_c;

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    mmio_board_input_reader_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .pin    (key[i]),
      .stable (key_stable[i]),
      .rise_c (key_rise_c[i])
    );
  end

  // Switches report level only; their rise pulses are not used.
  for (genvar i = 0; i < NSW; i++) begin : g_sw
    mmio_board_input_reader_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .pin    (Switch[i]),
      .stable (sw_stable[i]),
      .rise_c (unused_sw_rise[i])
    );
  end

  assign unused_bits = ^{addr[1:0], wdata[DATA_W-1:NKEY]};

  // Register-file next state; a new press beats a same-cycle clear.
  always_comb begin
    sel_c          = reg_sel_e'(addr[3:2]);
    wr_c           = cs & we;
    rd_c           = cs & ~we;
    w1c_c          = '0;
    irq_en_nx_c    = irq_en;
    rdata_nx_c     = '0;
    if (wr_c && (sel_c == REG_KEY_EVENT)) begin
      w1c_c = wdata[NKEY-1:0];
    end
    if (wr_c && (sel_c == REG_IRQ_EN)) begin
      irq_en_nx_c = wdata[NKEY-1:0];
    end
    key_event_nx_c = (key_event & ~w1c_c) | key_rise_c;
    case (sel_c)
      REG_KEY_STATE: rdata_nx_c = DATA_W'(key_stable);
      REG_SW_STATE:  rdata_nx_c = DATA_W'(sw_stable);
      REG_KEY_EVENT: rdata_nx_c = DATA_W'(key_event);
      REG_IRQ_EN:    rdata_nx_c = DATA_W'(irq_en);
      default:       rdata_nx_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_event <= '0;
      irq_en    <= '0;
      rdata     <= '0;
      irq       <= 1'b0;
    end else begin
      key_event <= key_event_nx_c;
      irq_en    <= irq_en_nx_c;
      irq       <= |(key_event_nx_c & irq_en_nx_c);
      if (rd_c) begin
        rdata <= rdata_nx_c;
      end
    end
  end

endmodule
